pingpong_frame_buffer: RTL and testbench
========================================

Name: pingpong_frame_buffer

Overview:
- Parametrised ingest buffer between the 32-bit receiver input and the DSP data-memory banks.
- Accepts wide input samples over a valid/ready handshake and serialises each into WORD_W-bit words.
- Fills one sram bank per frame, rotating through NUM_BANKS banks.
- Hands each full bank to the DSP and reclaims it on a release pulse; the DSP never reads a bank that is still being filled.

Parameters:
- IN_W, 32: input sample width; must be a multiple of WORD_W.
- WORD_W, 16: data-memory word width.
- ADDR_W, 16: data-memory address width.
- FRAME_LEN, 256: words per frame; a multiple of LANES (IN_W/WORD_W); FRAME_LEN <= 2^ADDR_W.
- NUM_BANKS, 2: number of data-memory banks, 2..4.
- DROP_ON_FULL, 0:
  - 0: stall input (in_ready low) when no bank is free.
  - 1: keep in_ready high, drop samples, count them.
- BANK_W, 2: width of bank-index ports; must be >= clog2(NUM_BANKS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active high.
- in_valid  in  1  input sample valid.
- in_data  in  IN_W  input sample.
- in_ready  out  1  buffer can accept a sample this cycle.
- wr_en  out  NUM_BANKS  per-bank write enable, one-hot or zero.
- wr_addr  out  NUM_BANKS*ADDR_W  per-bank write address, bank k at slice k.
- wr_data  out  NUM_BANKS*WORD_W  per-bank write data, bank k at slice k.
- frame_done  out  1  one-cycle pulse: a bank has been filled.
- frame_bank  out  BANK_W  index of the bank just filled; valid with frame_done.
- release  in  1  DSP finished with a bank (one-cycle pulse).
- release_bank  in  BANK_W  bank being returned; sampled with release.
- release_err  out  1  sticky: release of a bank not held by the DSP.
- drop_count  out  16  samples dropped (DROP_ON_FULL=1 only); saturates at 0xFFFF.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All banks free; fill_bank=0; word address 0; serializer idle.
  - in_ready=0 during reset, 1 on the first cycle after.
  - wr_en=0, wr_addr=0, wr_data=0, frame_done=0, frame_bank=0, release_err=0, drop_count=0.
  - Reset mid-frame or mid-serialisation discards the partial frame; no frame_done is issued for it.
- State machine:
  - IDLE: wait for a handshake.
  - SERIAL: emit LANES words.
  - WAIT_BANK: next bank held by DSP.
- Transitions:
  - IDLE -> SERIAL on in_valid & in_ready.
  - SERIAL -> IDLE after the last lane when no frame completes.
  - At frame end: -> IDLE if the next bank is free, else -> WAIT_BANK.
  - WAIT_BANK -> IDLE the cycle after that bank is released.
- Handshake and serialisation:
  - Transfer occurs when in_valid & in_ready are both high at the clock edge.
  - in_ready=1 only in IDLE, plus in WAIT_BANK when DROP_ON_FULL=1.
  - Words are emitted least-significant lane first: lane 0 = in_data[WORD_W-1:0].
  - Latency: sample accepted at edge N gives its lane-j write registered on the outputs during cycle N+1+j.
  - Peak throughput is one sample per LANES+1 cycles; the IDLE cycle is mandatory.
- Write port:
  - Only bank fill_bank has wr_en asserted.
  - Slices of non-selected banks hold their wr_addr/wr_data; their wr_en=0.
  - Address increments by 1 per word, 0..FRAME_LEN-1, then wraps to 0 for the next bank.
- Frame completion:
  - frame_done pulses in the same cycle as the write of word FRAME_LEN-1; frame_bank = that bank.
  - The bank is marked held from the next cycle.
  - fill_bank advances modulo NUM_BANKS.
- Release:
  - release with release_bank held clears the held bit next cycle.
  - release of a free bank, the current fill bank, or index >= NUM_BANKS sets release_err and changes no state.
  - Release in the same cycle as frame completion of a different bank: both take effect.
  - Release of the bank that fill_bank just advanced onto: fill proceeds without entering WAIT_BANK.
- Drop mode:
  - In WAIT_BANK with DROP_ON_FULL=1, accepted samples are discarded.
  - drop_count increments by 1 per discarded sample and saturates.
  - No write occurs.

Test Plan:
- Reset, then one sample 0xBEEF1234 with in_valid=1 -> cycle N+1: bank0 wr_en, addr 0, data 0x1234; cycle N+2: addr 1, data 0xBEEF; in_ready low for 2 cycles.
- FRAME_LEN=8, stream 4 samples back-to-back -> frame_done pulse with write of addr 7, frame_bank=0; next sample writes bank1 addr 0.
- NUM_BANKS=2, fill both banks without release -> after the second frame_done, in_ready=0 (WAIT_BANK); release bank0 -> in_ready=1 two cycles later, writes go to bank0 addr 0.
- DROP_ON_FULL=1, both banks held, present 5 samples -> in_ready stays 1, no wr_en, drop_count=5; release bank0 -> next sample written to bank0.
- release_bank=1 while bank1 is free -> release_err=1 and stays set; ownership unchanged; assert rst -> release_err=0.
- Assert rst between lane 0 and lane 1 of a sample at addr 5 -> no lane-1 write, no frame_done; the next sample writes bank0 addr 0.

Source files
------------

// File: rtl/pingpong_frame_buffer.sv
// ---------------------------------------------------------------------------
// pingpong_frame_buffer
//
// Ingest buffer between the wide receiver input and the DSP data-memory
// banks. Each accepted IN_W-bit sample is split into LANES = IN_W/WORD_W
// words, least-significant lane first, and written to consecutive addresses
// of the bank currently being filled. When a bank holds FRAME_LEN words it
// is handed to the DSP (frame_done/frame_bank) and filling moves to the next
// bank. The DSP hands banks back with a release pulse. A bank the DSP holds
// is never written.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous reset, active high
//   in_valid      input sample valid
//   in_data       input sample (IN_W bits)
//   in_ready      buffer accepts a sample this cycle
//   wr_en         per-bank write enable (one-hot or zero)
//   wr_addr       per-bank write address, bank k at slice k
//   wr_data       per-bank write data, bank k at slice k
//   frame_done    one-cycle pulse: a bank has just been filled
//   frame_bank    index of the bank just filled, valid with frame_done
//   release_pulse DSP has finished with a bank (one-cycle pulse); named
//                 this way because "release" is a reserved word
//   release_bank  bank being returned, sampled with release_pulse
//   release_err   sticky: a release named a bank the DSP does not hold
//   drop_count    samples discarded while no bank is free (DROP_ON_FULL=1),
//                 saturating at 0xFFFF
// ---------------------------------------------------------------------------
module pingpong_frame_buffer #(
  parameter int IN_W         = 32,
  parameter int WORD_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int FRAME_LEN    = 256,
  parameter int NUM_BANKS    = 2,
  parameter int DROP_ON_FULL = 0,
  parameter int BANK_W       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [IN_W-1:0]             in_data,
  output logic                        in_ready,
  output logic [NUM_BANKS-1:0]        wr_en,
  output logic [NUM_BANKS*ADDR_W-1:0] wr_addr,
  output logic [NUM_BANKS*WORD_W-1:0] wr_data,
  output logic                        frame_done,
  output logic [BANK_W-1:0]           frame_bank,
  input  logic                        release_pulse,
  input  logic [BANK_W-1:0]           release_bank,
  output logic                        release_err,
  output logic [15:0]                 drop_count
);

  localparam int LANES  = IN_W / WORD_W;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERIAL,
    WAIT_BANK
  } state_t;

  state_t               state;
  logic [BANK_W-1:0]    fill_bank;
  logic [ADDR_W-1:0]    word_addr;
  logic [LANE_W-1:0]    lane_idx;
  logic [IN_W-1:0]      sample_r;
  logic [NUM_BANKS-1:0] held;

  logic [NUM_BANKS-1:0] rel_hit;
  logic [NUM_BANKS-1:0] fill_onehot;
  logic [BANK_W-1:0]    next_bank;
  logic                 rel_bad;
  logic                 next_held;
  logic                 fill_held;
  logic                 last_lane;
  logic                 last_word;
  logic                 frame_end;
  logic                 ready_state;
  logic                 accept;

  // Decode of the current bank bookkeeping.
  // A release is legal only for a bank the DSP currently holds; that also
  // covers the bank being filled (never held while filling) and indices past
  // NUM_BANKS (no match in the loop). While stalled in WAIT_BANK the fill
  // bank is still held, so releasing it there is the normal way out.
  // next_held already accounts for a same-cycle release of the bank we are
  // about to advance onto, so that case skips WAIT_BANK entirely.
  always_comb begin
    rel_hit     = '0;
    fill_onehot = '0;
    next_held   = 1'b0;
    fill_held   = 1'b0;
    next_bank   = (fill_bank == LAST_BANK) ? '0 : fill_bank + BANK_W'(1);
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (release_pulse && (release_bank == BANK_W'(k)) && held[k]) begin
        rel_hit[k] = 1'b1;
      end
      if (fill_bank == BANK_W'(k)) begin
        fill_onehot[k] = 1'b1;
        fill_held      = held[k];
      end
      if (next_bank == BANK_W'(k)) begin
        next_held = held[k] & ~rel_hit[k];
      end
    end
    rel_bad     = release_pulse && (rel_hit == '0);
    last_lane   = (lane_idx == LAST_LANE);
    last_word   = (word_addr == LAST_ADDR);
    frame_end   = (state == SERIAL) && last_lane && last_word;
    ready_state = (state == IDLE) || ((DROP_ON_FULL != 0) && (state == WAIT_BANK));
  end

  // in_ready is forced low while reset is asserted so nothing is offered as
  // accepted during reset, yet it rises on the very first cycle after.
  assign in_ready = ready_state && !rst;
  assign accept   = in_valid && in_ready;

  // Main sequencer: handshake, serialiser, write port, frame hand-off and
  // bank ownership all advance together here. Write strobes and frame_done
  // default low every cycle so they are single-cycle pulses; the address and
  // data slices of banks not being written keep their last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fill_bank   <= '0;
      word_addr   <= '0;
      lane_idx    <= '0;
      sample_r    <= '0;
      held        <= '0;
      wr_en       <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_done  <= 1'b0;
      frame_bank  <= '0;
      release_err <= 1'b0;
      drop_count  <= '0;
    end else begin
      wr_en      <= '0;
      frame_done <= 1'b0;
      held       <= (held & ~rel_hit) | (frame_end ? fill_onehot : '0);
      if (rel_bad) begin
        release_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            sample_r <= in_data;
            lane_idx <= '0;
            state    <= SERIAL;
          end
        end

        SERIAL: begin
          wr_en <= fill_onehot;
          for (int k = 0; k < NUM_BANKS; k++) begin
            if (fill_onehot[k]) begin
              wr_addr[k*ADDR_W +: ADDR_W] <= word_addr;
              wr_data[k*WORD_W +: WORD_W] <= sample_r[WORD_W-1:0];
            end
          end
          sample_r <= sample_r >> WORD_W;
          lane_idx <= lane_idx + LANE_W'(1);
          // FRAME_LEN is a multiple of LANES, so the last word of a frame
          // always coincides with the last lane of a sample.
          if (frame_end) begin
            frame_done <= 1'b1;
            frame_bank <= fill_bank;
            fill_bank  <= next_bank;
            word_addr  <= '0;
            state      <= next_held ? WAIT_BANK : IDLE;
          end else begin
            word_addr <= word_addr + ADDR_W'(1);
            if (last_lane) begin
              state <= IDLE;
            end
          end
        end

        WAIT_BANK: begin
          if (!fill_held) begin
            state <= IDLE;
          end
          if ((DROP_ON_FULL != 0) && accept && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_pingpong_frame_buffer
//
// Two instances with FRAME_LEN=8, NUM_BANKS=2: unit 0 stalls when no bank
// is free, unit 1 drops. Stimulus pushes hand-computed expected writes into
// a per-unit queue; a negedge monitor pops and compares every write it sees.
// ---------------------------------------------------------------------------
module tb_pingpong_frame_buffer;

  localparam int FL = 8;

  typedef struct packed {
    logic [1:0]  bank;
    logic [15:0] addr;
    logic [15:0] data;
    logic        fd;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid    [2];
  logic [31:0] in_data     [2];
  logic        in_ready    [2];
  logic [1:0]  wr_en       [2];
  logic [31:0] wr_addr     [2];
  logic [31:0] wr_data     [2];
  logic        frame_done  [2];
  logic [1:0]  frame_bank  [2];
  logic        rel_pulse   [2];
  logic [1:0]  rel_bank    [2];
  logic        release_err [2];
  logic [15:0] drop_count  [2];

  wr_t q0[$];
  wr_t q1[$];
  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 1'b0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    pingpong_frame_buffer #(
      .IN_W(32), .WORD_W(16), .ADDR_W(16), .FRAME_LEN(FL),
      .NUM_BANKS(2), .DROP_ON_FULL(g), .BANK_W(2)
    ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_data(in_data[g]), .in_ready(in_ready[g]),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
      .frame_done(frame_done[g]), .frame_bank(frame_bank[g]),
      .release_pulse(rel_pulse[g]), .release_bank(rel_bank[g]),
      .release_err(release_err[g]), .drop_count(drop_count[g])
    );
  end

  // Single point of comparison; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
  endtask

  task automatic push_exp(input int u, input int bank, input int addr, input logic [15:0] data, input bit fd);
    wr_t e;
    e.bank = 2'(bank);
    e.addr = 16'(addr);
    e.data = data;
    e.fd   = fd;
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Compare one observed write against the head of the unit's queue.
  task automatic check_writes(input int u, input logic [1:0] en, input logic [31:0] addr,
                              input logic [31:0] data, input logic fd, input logic [1:0] fb);
    wr_t e;
    logic [1:0]  oh;
    logic [36:0] act_v, exp_v;
    if (en == 2'b00) begin
      if (fd !== 1'b0) checkOutput($sformatf("u%0d_frame_done_without_write", u), 64'(fd), 64'd0);
      return;
    end
    if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
      checkOutput($sformatf("u%0d_unexpected_write", u), 64'(en), 64'd0);
      return;
    end
    if (u == 0) e = q0.pop_front();
    else e = q1.pop_front();
    oh    = 2'b01 << e.bank;
    act_v = {en, addr[e.bank*16 +: 16], data[e.bank*16 +: 16], fd, (e.fd ? fb : 2'b00)};
    exp_v = {oh, e.addr, e.data, e.fd, (e.fd ? e.bank : 2'b00)};
    checkOutput($sformatf("u%0d_write_b%0d_a%0d", u, e.bank, e.addr), 64'(act_v), 64'(exp_v));
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the
  // active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check_writes(0, wr_en[0], wr_addr[0], wr_data[0], frame_done[0], frame_bank[0]);
      check_writes(1, wr_en[1], wr_addr[1], wr_data[1], frame_done[1], frame_bank[1]);
    end
  end

  // Offer one sample and hold it until accepted (bounded wait). When
  // expect_wr is set, both lane writes are queued for the monitor.
  task automatic applyStimulus(input int u, input logic [31:0] d, input int bank,
                               input int addr, input bit expect_wr);
    int waited;
    if (expect_wr) begin
      push_exp(u, bank, addr,     d[15:0],  (addr == FL - 1));
      push_exp(u, bank, addr + 1, d[31:16], (addr + 1 == FL - 1));
    end
    @(posedge clk); #1;
    in_valid[u] = 1'b1;
    in_data[u]  = d;
    waited = 0;
    @(negedge clk);
    while (!in_ready[u] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput($sformatf("u%0d_accept_%08h", u, d), 64'(in_ready[u]), 64'd1);
    @(posedge clk); #1;
    in_valid[u] = 1'b0;
  endtask

  task automatic do_release(input int u, input int bank);
    rel_pulse[u] = 1'b1;
    rel_bank[u]  = 2'(bank);
    @(posedge clk); #1;
    rel_pulse[u] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      rel_pulse[u] = 1'b0;
      rel_bank[u]  = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("u%0d_ready_in_reset", u), 64'(in_ready[u]), 64'd0);
      checkOutput($sformatf("u%0d_reset_ctl", u),
                  64'({wr_en[u], wr_addr[u], frame_done[u], frame_bank[u], release_err[u]}), 64'd0);
      checkOutput($sformatf("u%0d_reset_data", u), 64'({wr_data[u], drop_count[u]}), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 2; u++)
      checkOutput($sformatf("u%0d_ready_after_reset", u), 64'(in_ready[u]), 64'd1);

    // Latency of a single sample: nothing, lane 0, lane 1 with ready back.
    applyStimulus(0, 32'hBEEF1234, 0, 0, 1);
    @(negedge clk); checkOutput("u0_lat_accept_cycle", 64'({wr_en[0], in_ready[0]}), 64'(3'b000));
    @(negedge clk); checkOutput("u0_lat_lane0",        64'({wr_en[0], in_ready[0]}), 64'(3'b010));
    @(negedge clk); checkOutput("u0_lat_lane1",        64'({wr_en[0], in_ready[0]}), 64'(3'b011));

    // Finish bank 0 (frame_done on addr 7), then fill bank 1.
    applyStimulus(0, 32'h2222_1111, 0, 2, 1);
    applyStimulus(0, 32'h4444_3333, 0, 4, 1);
    applyStimulus(0, 32'h6666_5555, 0, 6, 1);
    applyStimulus(0, 32'h0B01_0B00, 1, 0, 1);
    applyStimulus(0, 32'h0B03_0B02, 1, 2, 1);
    applyStimulus(0, 32'h0B05_0B04, 1, 4, 1);
    applyStimulus(0, 32'h0B07_0B06, 1, 6, 1);
    repeat (4) @(negedge clk);
    checkOutput("u0_stall_ready", 64'(in_ready[0]), 64'd0);

    // Release bank 0: ready returns two cycles after the release cycle.
    @(negedge clk);
    do_release(0, 0);
    @(negedge clk); checkOutput("u0_ready_cycle1_after_release", 64'(in_ready[0]), 64'd0);
    @(negedge clk); checkOutput("u0_ready_cycle2_after_release", 64'(in_ready[0]), 64'd1);
    applyStimulus(0, 32'hCAFE_F00D, 0, 0, 1);

    // Legal release of bank 1, then an illegal repeat of it.
    do_release(0, 1);
    @(negedge clk); checkOutput("u0_legal_release_no_err", 64'(release_err[0]), 64'd0);
    do_release(0, 1);
    @(negedge clk); checkOutput("u0_release_err_set", 64'(release_err[0]), 64'd1);
    repeat (3) @(negedge clk);
    checkOutput("u0_release_err_sticky", 64'(release_err[0]), 64'd1);

    // Bank 0 completes; bank 1 is free, so filling continues without a stall.
    applyStimulus(0, 32'h0003_0002, 0, 2, 1);
    applyStimulus(0, 32'h0005_0004, 0, 4, 1);
    applyStimulus(0, 32'h0007_0006, 0, 6, 1);
    applyStimulus(0, 32'h1101_1100, 1, 0, 1);
    applyStimulus(0, 32'h1103_1102, 1, 2, 1);

    // Reset between lane 0 (addr 4) and lane 1 (addr 5).
    push_exp(0, 1, 4, 16'h1104, 1'b0);
    applyStimulus(0, 32'h1105_1104, 1, 4, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("u0_err_cleared_by_reset", 64'(release_err[0]), 64'd0);
    checkOutput("u0_ready_after_mid_reset", 64'({wr_en[0], in_ready[0]}), 64'(3'b001));
    applyStimulus(0, 32'hA5A5_5A5A, 0, 0, 1);

    // Drop-mode unit: fill both banks, then offer five samples.
    applyStimulus(1, 32'h1000_0001, 0, 0, 1);
    applyStimulus(1, 32'h1000_0002, 0, 2, 1);
    applyStimulus(1, 32'h1000_0003, 0, 4, 1);
    applyStimulus(1, 32'h1000_0004, 0, 6, 1);
    applyStimulus(1, 32'h2000_0001, 1, 0, 1);
    applyStimulus(1, 32'h2000_0002, 1, 2, 1);
    applyStimulus(1, 32'h2000_0003, 1, 4, 1);
    applyStimulus(1, 32'h2000_0004, 1, 6, 1);
    repeat (4) @(negedge clk);
    checkOutput("u1_full_ready_high", 64'(in_ready[1]), 64'd1);
    checkOutput("u1_full_drop_zero", 64'(drop_count[1]), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'hDEAD_0000 + 32'(i), 0, 0, 0);
    @(negedge clk);
    checkOutput("u1_drop_count_5", 64'(drop_count[1]), 64'd5);
    checkOutput("u1_ready_while_dropping", 64'(in_ready[1]), 64'd1);
    do_release(1, 3);
    @(negedge clk); checkOutput("u1_release_out_of_range_err", 64'(release_err[1]), 64'd1);
    do_release(1, 0);
    applyStimulus(1, 32'h7777_8888, 0, 0, 1);
    @(negedge clk);
    checkOutput("u1_drop_count_held", 64'(drop_count[1]), 64'd5);

    repeat (6) @(negedge clk);
    checkOutput("u0_all_writes_seen", 64'(q0.size()), 64'd0);
    checkOutput("u1_all_writes_seen", 64'(q1.size()), 64'd0);
    checkOutput("u0_stall_mode_no_drops", 64'(drop_count[0]), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
